stream_byte_packer: RTL and testbench
=====================================

// Module: stream_byte_packer
// PURPOSE
//  Packs partially filled input beats (valid bytes contiguous from byte 0) into dense NUM_BYTES-wide output beats.
//  Packets are delimited by in_last; residual bytes never cross a packet boundary.
//  Full ready/valid backpressure on both sides, so it sits between a variable-length producer and a wide DMA/AXI-S sink.
//  Successor to the 64-byte packer: parametrised width, registered output skid, two-beat flush on last, length checking.
// PARAMETERS
//  NUM_BYTES   64  bytes per beat, in and out (power of two, >= 4)
//  CNT_W       $clog2(NUM_BYTES)+1  width of in_num_bytes_valid
// PORTS
//  clk                 in   1            clock; all logic on rising edge
//  rst                 in   1            reset, asynchronous, active-high
//  in_ready            out  1            upstream may present a beat
//  in_data             in   NUM_BYTES*8  input bytes; byte i at [i*8+:8]
//  in_valid            in   1            in_data/in_last/in_num_bytes_valid valid
//  in_last             in   1            beat closes the packet
//  in_num_bytes_valid  in   CNT_W        valid bytes in beat, 0..NUM_BYTES
//  out_ready           in   1            downstream accepts
//  out_data            out  NUM_BYTES*8  packed bytes; invalid bytes driven 0
//  out_keep            out  NUM_BYTES    byte enables, always contiguous from bit 0
//  out_valid           out  1            out_* valid
//  out_last            out  1            final beat of packet
//  err_len             out  1            sticky: in_num_bytes_valid > NUM_BYTES seen
// BEHAVIOUR
//  Reset (async assert, sync deassert use): out_data=0, out_keep=0, out_valid=0, out_last=0, err_len=0, residual count=0, state=PACK.
//  Handshake: in accepted when in_valid&in_ready; out consumed when out_valid&out_ready. out_* stable while out_valid&!out_ready.
//  in_ready = (state==PACK) & (!out_valid | out_ready). Combinational in out_ready only; no dependency on in_valid.
//  Residual: buffer res[NUM_BYTES-1 bytes], count cnt in 0..NUM_BYTES-1 between packets and beats.
//  Accepted beat, n = min(in_num_bytes_valid, NUM_BYTES) (excess sets err_len, clamped), total t = cnt+n (0..2*NUM_BYTES-1):
//   - t <  NUM_BYTES, !last: res <= res | in<<(8*cnt); cnt<=t; no output.
//   - t >= NUM_BYTES, !last: emit full beat (keep all 1, last 0); res <= upper t-NUM_BYTES bytes; cnt<=t-NUM_BYTES.
//   - last, t <= NUM_BYTES: emit one beat, keep = t low bits set, last=1; cnt<=0. t==0 emits keep=0,last=1 (empty packet preserved).
//   - last, t >  NUM_BYTES: emit full beat last=0; res<=remainder; go FLUSH.
//  FLUSH: in_ready=0; when output slot frees, emit residual beat keep=cnt bits, last=1; cnt<=0; return PACK.
//  Latency: accept->out_valid one cycle. Throughput: one input beat/cycle when out_ready held high (FLUSH costs one bubble).
//  in_valid without in_ready: no state change. out_valid=1 & out_ready=1 & new accept in same cycle: replace output register.
//  Bytes above keep in out_data and in res are 0. in_data bytes at/above n are ignored.
//  Zero-count non-last beat: accepted, no effect. err_len clears only on rst.
//  Reset mid-packet: residual bytes and pending output discarded; no partial beat emitted.
//  Arithmetic: t computed at CNT_W+1 bits; shift amount 8*cnt with cnt < NUM_BYTES.
// STRUCTURE
//  Package stream_pack_pkg: typedef enum logic {PACK, FLUSH} pack_state_t; localparams BYTE_W=8, CNT_W; function keep_from_count().
//  Sub-module byte_shift_merge (combinational): {hi,lo} = {0,res} | (in_masked << 8*cnt), 2*NUM_BYTES wide.
//  Top: FSM, residual/count regs, output register slice, err_len flag.
// TESTING
//  NUM_BYTES=64; in n=16 x4, last on 4th, out_ready=1 -> one beat keep=all1 last=1, bytes 0..63 in order.
//  n=40 then n=40 last -> beat1 keep all1 last=0; beat2 keep=16 bits last=1; in_ready=0 for one cycle during FLUSH.
//  n=64 every cycle 10 beats, out_ready=1 -> 10 out beats back-to-back, in_ready never drops.
//  n=30,30 with out_ready toggling 1/0 random -> out_data/keep stable while stalled; byte stream identical to reference model.
//  n=0 last on empty buffer -> one beat keep=0 last=1; n=70 -> err_len=1, treated as 64 bytes.
//  rst asserted with cnt=20 and out_valid=1 -> all outputs 0 immediately; next packet starts at byte 0.

Source files
------------

// File: rtl/stream_pack_pkg.sv
// Shared types and helpers for the stream byte packer.
// Keep masks are built at a fixed maximum width and truncated by users.
package stream_pack_pkg;

    typedef enum logic {PACK, FLUSH} pack_state_t;

    localparam int BYTE_W    = 8;
    localparam int DEF_BYTES = 64;
    localparam int CNT_W     = $clog2(DEF_BYTES) + 1;
    localparam int KEEP_MAX  = 256;

    function automatic logic [KEEP_MAX-1:0] keep_from_count(
        input int unsigned count
    );
        logic [KEEP_MAX-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            k[i] = (i < count);
        end
        return k;
    endfunction

endpackage

// File: rtl/stream_byte_packer_merge.sv
// Combinational merge of residual bytes with a new beat shifted
// up past the residual count: {hi,lo} = {0,res} | (data << 8*cnt).
module byte_shift_merge #(
    parameter int NUM_BYTES = 64,
    parameter int CW        = 6
) (
    input  logic [NUM_BYTES*8-1:0]   res,
    input  logic [NUM_BYTES*8-1:0]   data,
    input  logic [CW-1:0]            cnt,
    output logic [2*NUM_BYTES*8-1:0] merged
);
    import stream_pack_pkg::*;

    localparam int DW = NUM_BYTES * BYTE_W;

    logic [CW+2:0] sh;

    assign sh = (CW+3)'(cnt) << $clog2(BYTE_W);
    assign merged = {{DW{1'b0}}, res} | ({{DW{1'b0}}, data} << sh);

endmodule

// File: rtl/stream_byte_packer.sv
// Packs sparse input beats into dense output beats, never letting
// residual bytes cross a packet boundary.
module stream_byte_packer #(
    parameter int NUM_BYTES = 64,
    parameter int CNT_W     = $clog2(NUM_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   in_ready,
    input  logic [NUM_BYTES*8-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [CNT_W-1:0]       in_num_bytes_valid,
    input  logic                   out_ready,
    output logic [NUM_BYTES*8-1:0] out_data,
    output logic [NUM_BYTES-1:0]   out_keep,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   err_len
);
    import stream_pack_pkg::*;

    localparam int CW = CNT_W - 1;
    localparam int DW = NUM_BYTES * BYTE_W;
    localparam logic [CNT_W-1:0] NB_N = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W:0]   NB_T = (CNT_W+1)'(NUM_BYTES);

    pack_state_t state;
    logic [DW-1:0] res;
    logic [CW-1:0] cnt;

    logic [CNT_W-1:0] n;
    logic [CNT_W:0] t;
    logic [NUM_BYTES-1:0] n_keep;
    logic [NUM_BYTES-1:0] t_keep;
    logic [NUM_BYTES-1:0] c_keep;
    logic [DW-1:0] in_masked;
    logic [2*DW-1:0] merged;
    logic slot_free;
    logic accept;
    logic over;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == PACK) && slot_free;
    assign accept    = in_valid && in_ready;

    // Oversized counts are clamped to a full beat.
    assign over = in_num_bytes_valid > NB_N;
    assign n    = over ? NB_N : in_num_bytes_valid;
    assign t    = {1'b0, n} + (CNT_W+1)'(cnt);

    assign n_keep = NUM_BYTES'(keep_from_count(32'(n)));
    assign t_keep = NUM_BYTES'(keep_from_count(32'(t)));
    assign c_keep = NUM_BYTES'(keep_from_count(32'(cnt)));

    always_comb begin
        in_masked = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (n_keep[i]) begin
                in_masked[i*BYTE_W +: BYTE_W] = in_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    byte_shift_merge #(
        .NUM_BYTES (NUM_BYTES),
        .CW        (CW)
    ) u_merge (
        .res    (res),
        .data   (in_masked),
        .cnt    (cnt),
        .merged (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PACK;
            res       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (over) begin
                    err_len <= 1'b1;
                end
                if (!in_last && t < NB_T) begin
                    res <= merged[DW-1:0];
                    cnt <= t[CW-1:0];
                end else if (in_last && t <= NB_T) begin
                    out_data  <= merged[DW-1:0];
                    out_keep  <= t_keep;
                    out_last  <= 1'b1;
                    out_valid <= 1'b1;
                    res       <= '0;
                    cnt       <= '0;
                end else begin
                    // Full beat out; remainder is t-NUM_BYTES = low bits of t.
                    out_data  <= merged[DW-1:0];
                    out_keep  <= '1;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    res       <= merged[2*DW-1:DW];
                    cnt       <= t[CW-1:0];
                    if (in_last) begin
                        state <= FLUSH;
                    end
                end
            end else if (state == FLUSH && slot_free) begin
                out_data  <= res;
                out_keep  <= c_keep;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
                res       <= '0;
                cnt       <= '0;
                state     <= PACK;
            end
        end
    end

endmodule

// File: tb/tb_stream_byte_packer.sv
// Bench for stream_byte_packer: vector table, throughput, random
// backpressure with a byte-queue scoreboard, and mid-packet reset.
module tb_stream_byte_packer;

    localparam int NB = 64;
    localparam int CW = 7;
    localparam int DW = NB * 8;

    logic clk = 1'b0;
    logic rst;
    logic in_ready;
    logic [DW-1:0] in_data;
    logic in_valid;
    logic in_last;
    logic [CW-1:0] in_num_bytes_valid;
    logic out_ready;
    logic [DW-1:0] out_data;
    logic [NB-1:0] out_keep;
    logic out_valid;
    logic out_last;
    logic err_len;

    always #5 clk = ~clk;

    stream_byte_packer #(.NUM_BYTES(NB)) dut (
        .clk                (clk),
        .rst                (rst),
        .in_ready           (in_ready),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_last            (in_last),
        .in_num_bytes_valid (in_num_bytes_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_keep           (out_keep),
        .out_valid          (out_valid),
        .out_last           (out_last),
        .err_len            (err_len)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        int   n;
        logic last;
        logic ev;
        int   kc;
        logic el;
        logic er;
    } vec_t;

    beat_t exp_q[$];
    logic [7:0] pkt[$];
    int n_checks = 0;
    int n_fail = 0;
    int unsigned seq = 0;
    bit rand_mode = 0;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] kmask(input int k);
        if (k >= NB) return '1;
        return (64'd1 << k) - 64'd1;
    endfunction

    task automatic model_emit(input int k, input logic l);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < k; i++) b.data[i*8 +: 8] = pkt.pop_front();
        b.keep = kmask(k);
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Scoreboard: consume on output handshake, model on input accept.
    logic  stall_q = 1'b0;
    beat_t held;
    beat_t got;
    int    nn;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pkt.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q && out_valid) begin
                chk("stall_data", out_data, held.data);
                chk("stall_keep", DW'(out_keep), DW'(held.keep));
                chk("stall_last", DW'(out_last), DW'(held.last));
            end
            stall_q   = out_valid && !out_ready;
            held.data = out_data;
            held.keep = out_keep;
            held.last = out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got keep %h want none", out_keep);
                end else begin
                    got = exp_q.pop_front();
                    chk("sb_data", out_data, got.data);
                    chk("sb_keep", DW'(out_keep), DW'(got.keep));
                    chk("sb_last", DW'(out_last), DW'(got.last));
                end
            end
            if (in_valid && in_ready) begin
                nn = (in_num_bytes_valid > 7'd64) ? NB : int'(in_num_bytes_valid);
                for (int i = 0; i < nn; i++) pkt.push_back(in_data[i*8 +: 8]);
                if (in_last) begin
                    while (pkt.size() > NB) model_emit(NB, 1'b0);
                    model_emit(pkt.size(), 1'b1);
                end else begin
                    while (pkt.size() >= NB) model_emit(NB, 1'b0);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input int n, input logic last);
        bit acc = 0;
        in_num_bytes_valid = 7'(n);
        in_last = last;
        for (int i = 0; i < NB; i++) begin
            in_data[i*8 +: 8] = (i < n) ? 8'(seq + 32'(i)) : 8'(i ^ 165);
        end
        in_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready 0 want 1");
        end
        seq += (n > NB) ? NB : n;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[14];
    int unsigned s0;

    initial begin
        tbl = '{
            '{16, 1'b0, 1'b0,  0, 1'b0, 1'b1},
            '{16, 1'b0, 1'b0,  0, 1'b0, 1'b1},
            '{16, 1'b0, 1'b0,  0, 1'b0, 1'b1},
            '{16, 1'b1, 1'b1, 64, 1'b1, 1'b1},
            '{40, 1'b0, 1'b0,  0, 1'b0, 1'b1},
            '{40, 1'b1, 1'b1, 64, 1'b0, 1'b0},
            '{-1, 1'b0, 1'b1, 16, 1'b1, 1'b1},
            '{ 0, 1'b1, 1'b1,  0, 1'b1, 1'b1},
            '{64, 1'b0, 1'b1, 64, 1'b0, 1'b1},
            '{ 0, 1'b0, 1'b0,  0, 1'b0, 1'b1},
            '{10, 1'b0, 1'b0,  0, 1'b0, 1'b1},
            '{70, 1'b1, 1'b1, 64, 1'b0, 1'b0},
            '{-1, 1'b0, 1'b1, 10, 1'b1, 1'b1},
            '{-1, 1'b0, 1'b0,  0, 1'b0, 1'b1}
        };
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        in_num_bytes_valid = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", DW'(out_valid), '0);
        chk("rst_keep", DW'(out_keep), '0);
        chk("rst_data", out_data, '0);
        chk("rst_last", DW'(out_last), '0);
        chk("rst_err", DW'(err_len), '0);
        chk("rst_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();

        for (int v = 0; v < 14; v++) begin
            if (tbl[v].n < 0) idle();
            else send(tbl[v].n, tbl[v].last);
            chk($sformatf("vec%0d_valid", v), DW'(out_valid), DW'(tbl[v].ev));
            chk($sformatf("vec%0d_ready", v), DW'(in_ready), DW'(tbl[v].er));
            if (tbl[v].ev) begin
                chk($sformatf("vec%0d_keep", v), DW'(out_keep), DW'(kmask(tbl[v].kc)));
                chk($sformatf("vec%0d_last", v), DW'(out_last), DW'(tbl[v].el));
            end
            if (v == 10) chk("err_before", DW'(err_len), '0);
        end
        chk("err_after", DW'(err_len), DW'(1));

        for (int b = 0; b < 10; b++) begin
            send(64, b == 9);
            chk($sformatf("tput%0d_ready", b), DW'(in_ready), DW'(1));
            chk($sformatf("tput%0d_valid", b), DW'(out_valid), DW'(1));
        end
        idle();

        rand_mode = 1;
        for (int b = 0; b < 24; b++) send(30, (b % 4) == 3);
        rand_mode = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) idle();
        chk("drain_rand", DW'(exp_q.size()), '0);

        out_ready = 1'b0;
        send(20, 1'b0);
        send(64, 1'b0);
        chk("pre_rst_valid", DW'(out_valid), DW'(1));
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", DW'(out_valid), '0);
        chk("mid_rst_keep", DW'(out_keep), '0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_last", DW'(out_last), '0);
        chk("mid_rst_err", DW'(err_len), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle();
        s0 = seq;
        send(16, 1'b1);
        chk("post_rst_keep", DW'(out_keep), DW'(kmask(16)));
        chk("post_rst_byte0", DW'(out_data[7:0]), DW'(8'(s0)));
        chk("post_rst_last", DW'(out_last), DW'(1));
        idle();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle();
        chk("drain_end", DW'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
